pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter PC_W, default 16: program counter width in bits.
REQ-002 Parameter BR_W, default 6: branch offset width, signed, in instruction words.
REQ-003 Parameter J_W, default 12: jump offset width, signed, in instruction words.
REQ-004 Parameter RAS_DEPTH, default 4: return-address stack entries, power of two, minimum 2.
REQ-005 Parameter INT_VEC, default 16'h0010: interrupt handler address, PC_W bits wide.
REQ-006 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-007 Port clk, input, 1: rising-edge clock.
REQ-008 Port reset, input, 1: asynchronous, active-low reset.
REQ-009 Port clk_en, input, 1: advance enable; when low, all state holds.
REQ-010 Port halt, input, 1: HALT instruction is decoded.
REQ-011 Port branch_taken, input, 1: the branch comparator resolves taken.
REQ-012 Port branch_imm, input, BR_W: signed branch word offset.
REQ-013 Port jump_taken, input, 1: J or JL is decoded.
REQ-014 Port jump_link, input, 1: qualifies jump_taken as JL.
REQ-015 Port jump_imm, input, J_W: signed jump word offset.
REQ-016 Port ret, input, 1: RETURN is decoded.
REQ-017 Port int_en_cmd, input, 1: INT_ENABLE is decoded.
REQ-018 Port int_dis_cmd, input, 1: INT_DISABLE is decoded.
REQ-019 Port int_req, input, 1: level-sensitive interrupt request, either external or INT_TRIGGER.
REQ-020 Port pc, output, PC_W: current fetch address.
REQ-021 Port int_active, output, 1: high while in the interrupt handler.
REQ-022 Port halted, output, 1: high while the core is halted.
REQ-023 Port ras_overflow, output, 1: sticky flag, set when a push overwrites an entry.
REQ-024 Port ras_underflow, output, 1: sticky flag, set when a pop hits an empty stack.

Function
REQ-025 The block SHALL be a state machine with states RUN, HALTED and ISR; all updates SHALL occur only on rising clk with clk_en high.
REQ-026 seq = pc + 2; br_tgt = pc + 2 + (sext(branch_imm) << 1); j_tgt = pc + 2 + (sext(jump_imm) << 1); all arithmetic SHALL be modulo 2^PC_W.
REQ-027 In RUN and ISR, next-PC priority SHALL be: interrupt entry, then halt, then ret, then jump, then branch, then seq.
REQ-028 Interrupt entry SHALL occur only in RUN with ie=1 and int_req=1: push seq, set pc=INT_VEC, clear ie, go to ISR.
REQ-029 halt in RUN or ISR SHALL hold pc and go to HALTED; the state before the halt SHALL be remembered.
REQ-030 HALTED with ie=1 and int_req=1 SHALL push pc+2 and enter ISR at INT_VEC; otherwise pc holds until reset.
REQ-031 ret SHALL pop the stack into pc; ret in ISR SHALL additionally set ie=1 and return to RUN.
REQ-032 jump with jump_link SHALL push seq and then load j_tgt; jump without jump_link SHALL only load j_tgt.
REQ-033 The RAS SHALL be circular. A push when full SHALL overwrite the oldest entry, keep the count at RAS_DEPTH, and set ras_overflow.
REQ-034 A pop when empty SHALL set pc=seq and set ras_underflow; the count SHALL stay 0.
REQ-035 Only one push or pop SHALL occur per cycle, guaranteed by the priority order.
REQ-036 int_en_cmd SHALL set ie and int_dis_cmd SHALL clear it; if both are asserted, disable wins.
REQ-037 ie changes SHALL take effect from the next cycle; interrupt entry in the same cycle SHALL use the old ie.
REQ-038 Nested interrupts SHALL NOT be taken in ISR, regardless of ie.
REQ-039 int_active SHALL equal (state==ISR) and halted SHALL equal (state==HALTED); both are registered outputs.

Reset
REQ-040 Asserting reset (low) SHALL immediately set pc=0, state=RUN, ie=0, RAS count=0, both sticky flags=0, int_active=0 and halted=0.
REQ-041 Reset SHALL abort any operation in progress, including one mid-ISR; RAS contents are don't-care after reset.
REQ-042 After reset deasserts, the first enabled edge SHALL produce pc=2, absent other commands.

Structure
REQ-043 The state encoding (RUN/HALTED/ISR) and the INT_VEC default SHALL live in the shared processor package, alongside the opcode constants.
REQ-044 The return-address stack SHALL be a sub-module named ras_stack, parametrised by width and depth, with push, pop, full, empty and top signals.
REQ-045 The next-PC mux and the state machine SHALL remain in pc_unit.

Verification
REQ-046 Reset, then 3 enabled cycles with no commands -> pc sequence 2, 4, 6; one cycle with clk_en=0 -> pc holds at 6.
REQ-047 pc=0x0010 with branch_taken and branch_imm=6'b111110 (-2) -> pc=0x000E; pc=0xFFFE with seq -> pc wraps to 0x0000.
REQ-048 At pc=0x0100, JL with jump_imm=0x010 -> pc=0x0122 and top of RAS=0x0102; then ret -> pc=0x0102.
REQ-049 With RAS_DEPTH=4, 5 JLs then 5 rets -> ras_overflow=1 after the 5th push; 4 correct return addresses (newest first), then ras_underflow=1 and pc=seq.
REQ-050 int_en_cmd, then int_req high at pc=0x0040 -> pc=0x0010 with int_active=1; int_req held in ISR -> no re-entry; ret -> pc=0x0042, int_active=0, ie=1.
REQ-051 halt at pc=0x0020 -> pc holds and halted=1; int_req with ie=1 -> pc=0x0010 in ISR; ret -> pc=0x0022; a reset pulse mid-ISR -> pc=0 and all flags cleared.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// ============================================================================
// Module      : pc_unit_pkg
// Description : Shared processor constants: sequencer states, interrupt
//               vector default and instruction opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_ISR    = 2'd2
    } pc_state_e;

    localparam logic [15:0] c_INT_VEC_DEFAULT = 16'h0010;

    localparam logic [3:0] c_OP_NOP         = 4'h0;
    localparam logic [3:0] c_OP_BRANCH      = 4'h1;
    localparam logic [3:0] c_OP_J           = 4'h2;
    localparam logic [3:0] c_OP_JL          = 4'h3;
    localparam logic [3:0] c_OP_RETURN      = 4'h4;
    localparam logic [3:0] c_OP_HALT        = 4'h5;
    localparam logic [3:0] c_OP_INT_ENABLE  = 4'h6;
    localparam logic [3:0] c_OP_INT_DISABLE = 4'h7;
    localparam logic [3:0] c_OP_INT_TRIGGER = 4'h8;

endpackage

`default_nettype wire

// File: rtl/ras_stack.sv
// ============================================================================
// Module      : ras_stack
// Description : Circular return-address stack; a push when full overwrites
//               the oldest entry, a pop when empty is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_sp;
    logic [AW:0]      r_count;
    logic [AW-1:0]    w_top_idx;

    // r_sp is the next write slot; DEPTH is a power of two so it wraps freely
    assign w_top_idx = r_sp - AW'(1);
    assign top       = r_mem[w_top_idx];
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sp    <= '0;
            r_count <= '0;
        end else if (push) begin
            r_sp <= r_sp + AW'(1);
            if (!full) begin
                r_count <= r_count + (AW+1)'(1);
            end
        end else if (pop && !empty) begin
            r_sp    <= w_top_idx;
            r_count <= r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_sp] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module      : pc_unit
// Description : Program counter sequencer with branch/jump/return, HALT and
//               single-level interrupt handling backed by a return stack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              PC_W      = 16,
    parameter int              BR_W      = 6,
    parameter int              J_W       = 12,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] INT_VEC   = PC_W'(c_INT_VEC_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_en,
    input  logic            halt,
    input  logic            branch_taken,
    input  logic [BR_W-1:0] branch_imm,
    input  logic            jump_taken,
    input  logic            jump_link,
    input  logic [J_W-1:0]  jump_imm,
    input  logic            ret,
    input  logic            int_en_cmd,
    input  logic            int_dis_cmd,
    input  logic            int_req,
    output logic [PC_W-1:0] pc,
    output logic            int_active,
    output logic            halted,
    output logic            ras_overflow,
    output logic            ras_underflow
);

    pc_state_e       r_state;
    logic            r_ie;
    logic            r_halt_from_isr;

    logic [PC_W-1:0] w_seq;
    logic [PC_W-1:0] w_br_tgt;
    logic [PC_W-1:0] w_j_tgt;
    logic [PC_W-1:0] w_ras_top;
    logic [PC_W-1:0] w_pc_next;
    logic            w_active;
    logic            w_take_int;
    logic            w_do_ret;
    logic            w_do_jump;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_ie_cmd;

    assign w_seq    = pc + PC_W'(2);
    assign w_br_tgt = w_seq + ({{(PC_W-BR_W){branch_imm[BR_W-1]}}, branch_imm} << 1);
    assign w_j_tgt  = w_seq + ({{(PC_W-J_W){jump_imm[J_W-1]}}, jump_imm} << 1);
    assign w_ie_cmd = int_dis_cmd ? 1'b0 : (int_en_cmd ? 1'b1 : r_ie);

    always_comb begin
        w_active   = (r_state == ST_RUN) || (r_state == ST_ISR);
        // A halt issued inside the handler still counts as handler context
        w_take_int = r_ie && int_req &&
                     ((r_state == ST_RUN) || ((r_state == ST_HALTED) && !r_halt_from_isr));
        w_do_ret   = w_active && !w_take_int && !halt && ret;
        w_do_jump  = w_active && !w_take_int && !halt && !ret && jump_taken;
        w_push     = clk_en && (w_take_int || (w_do_jump && jump_link));
        w_pop      = clk_en && w_do_ret;

        w_pc_next = w_seq;
        if (w_take_int) begin
            w_pc_next = INT_VEC;
        end else if (!w_active || halt) begin
            w_pc_next = pc;
        end else if (w_do_ret) begin
            w_pc_next = w_empty ? w_seq : w_ras_top;
        end else if (w_do_jump) begin
            w_pc_next = w_j_tgt;
        end else if (branch_taken) begin
            w_pc_next = w_br_tgt;
        end
    end

    ras_stack #(
        .WIDTH (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_seq),
        .top       (w_ras_top),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc              <= '0;
            r_state         <= ST_RUN;
            r_ie            <= 1'b0;
            r_halt_from_isr <= 1'b0;
            int_active      <= 1'b0;
            halted          <= 1'b0;
            ras_overflow    <= 1'b0;
            ras_underflow   <= 1'b0;
        end else if (clk_en) begin
            pc            <= w_pc_next;
            ras_overflow  <= ras_overflow | (w_push & w_full);
            ras_underflow <= ras_underflow | (w_pop & w_empty);
            r_ie          <= w_ie_cmd;
            case (r_state)
                ST_RUN: begin
                    if (w_take_int) begin
                        r_state    <= ST_ISR;
                        int_active <= 1'b1;
                        r_ie       <= 1'b0;
                    end else if (halt) begin
                        r_state         <= ST_HALTED;
                        halted          <= 1'b1;
                        r_halt_from_isr <= 1'b0;
                    end
                end
                ST_ISR: begin
                    if (halt) begin
                        r_state         <= ST_HALTED;
                        halted          <= 1'b1;
                        int_active      <= 1'b0;
                        r_halt_from_isr <= 1'b1;
                    end else if (ret) begin
                        r_state    <= ST_RUN;
                        int_active <= 1'b0;
                        r_ie       <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (w_take_int) begin
                        r_state    <= ST_ISR;
                        halted     <= 1'b0;
                        int_active <= 1'b1;
                        r_ie       <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    int_active <= 1'b0;
                    halted     <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module      : tb_pc_unit
// Description : Directed and randomized checks of pc_unit against a
//               queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;

    localparam int PC_W      = 16;
    localparam int BR_W      = 6;
    localparam int J_W       = 12;
    localparam int RAS_DEPTH = 4;
    localparam int INTV      = 'h10;
    localparam int M_RUN     = 0;
    localparam int M_HALT    = 1;
    localparam int M_ISR     = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            clk_en = 1'b0;
    logic            halt = 1'b0;
    logic            branch_taken = 1'b0;
    logic [BR_W-1:0] branch_imm = '0;
    logic            jump_taken = 1'b0;
    logic            jump_link = 1'b0;
    logic [J_W-1:0]  jump_imm = '0;
    logic            ret = 1'b0;
    logic            int_en_cmd = 1'b0;
    logic            int_dis_cmd = 1'b0;
    logic            int_req = 1'b0;
    logic [PC_W-1:0] pc;
    logic            int_active;
    logic            halted;
    logic            ras_overflow;
    logic            ras_underflow;

    int n_cmp = 0;
    int n_err = 0;

    int m_pc, m_state, m_ie, m_hfi, m_ovf, m_unf;
    int m_ras[$];

    pc_unit dut (
        .clk           (clk),
        .reset         (reset),
        .clk_en        (clk_en),
        .halt          (halt),
        .branch_taken  (branch_taken),
        .branch_imm    (branch_imm),
        .jump_taken    (jump_taken),
        .jump_link     (jump_link),
        .jump_imm      (jump_imm),
        .ret           (ret),
        .int_en_cmd    (int_en_cmd),
        .int_dis_cmd   (int_dis_cmd),
        .int_req       (int_req),
        .pc            (pc),
        .int_active    (int_active),
        .halted        (halted),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sext(input int v, input int w);
        return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_state = M_RUN; m_ie = 0; m_hfi = 0; m_ovf = 0; m_unf = 0;
        m_ras.delete();
    endtask

    task automatic model_push(input int v);
        if (m_ras.size() == RAS_DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1;
        end
        m_ras.push_back(v);
    endtask

    task automatic model_step();
        int seq, br, jt, ie_new;
        if (!clk_en) return;
        seq    = (m_pc + 2) & 'hFFFF;
        br     = (m_pc + 2 + 2 * sext(int'(branch_imm), BR_W)) & 'hFFFF;
        jt     = (m_pc + 2 + 2 * sext(int'(jump_imm), J_W)) & 'hFFFF;
        ie_new = int_dis_cmd ? 0 : (int_en_cmd ? 1 : m_ie);
        if (m_state == M_HALT) begin
            if (m_ie != 0 && int_req && m_hfi == 0) begin
                model_push(seq);
                m_pc = INTV; m_state = M_ISR; ie_new = 0;
            end
        end else if (m_state == M_RUN && m_ie != 0 && int_req) begin
            model_push(seq);
            m_pc = INTV; m_state = M_ISR; ie_new = 0;
        end else if (halt) begin
            m_hfi   = (m_state == M_ISR) ? 1 : 0;
            m_state = M_HALT;
        end else if (ret) begin
            if (m_ras.size() == 0) begin
                m_pc = seq; m_unf = 1;
            end else begin
                m_pc = m_ras.pop_back();
            end
            if (m_state == M_ISR) begin
                m_state = M_RUN; ie_new = 1;
            end
        end else if (jump_taken) begin
            if (jump_link) model_push(seq);
            m_pc = jt;
        end else if (branch_taken) begin
            m_pc = br;
        end else begin
            m_pc = seq;
        end
        m_ie = ie_new;
    endtask

    task automatic compare_all();
        check("pc", 32'(pc), 32'(m_pc));
        check("int_active", 32'(int_active), 32'(m_state == M_ISR));
        check("halted", 32'(halted), 32'(m_state == M_HALT));
        check("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
        check("ras_underflow", 32'(ras_underflow), 32'(m_unf));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear();
        clk_en = 1'b1; halt = 1'b0; branch_taken = 1'b0; branch_imm = '0;
        jump_taken = 1'b0; jump_link = 1'b0; jump_imm = '0; ret = 1'b0;
        int_en_cmd = 1'b0; int_dis_cmd = 1'b0; int_req = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        #2;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic jump_to(input logic [J_W-1:0] imm);
        clear(); jump_taken = 1'b1; jump_imm = imm;
        tick();
        clear();
    endtask

    initial begin
        clear();

        // Sequential advance and clock-enable hold
        reset_dut();
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("seq_pc", 32'(pc), 32'(2 * i));
        end
        clk_en = 1'b0;
        tick();
        check("hold_pc", 32'(pc), 32'h6);

        // Backward branch and wrap-around
        reset_dut();
        jump_to(12'd7);
        branch_taken = 1'b1; branch_imm = 6'b111110;
        tick();
        check("branch_back", 32'(pc), 32'h000E);
        reset_dut();
        jump_to(12'hFFE);
        check("pc_at_fffe", 32'(pc), 32'hFFFE);
        tick();
        check("pc_wrap", 32'(pc), 32'h0000);

        // JL then return
        reset_dut();
        jump_to(12'd127);
        jump_taken = 1'b1; jump_link = 1'b1; jump_imm = 12'h010;
        tick();
        check("jl_target", 32'(pc), 32'h0122);
        clear(); ret = 1'b1;
        tick();
        check("ret_addr", 32'(pc), 32'h0102);

        // Stack overflow then underflow
        reset_dut();
        clear(); jump_taken = 1'b1; jump_link = 1'b1;
        repeat (5) tick();
        check("ovf_after_5", 32'(ras_overflow), 32'h1);
        clear(); ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ret_chain", 32'(pc), 32'(10 - 2 * i));
        end
        tick();
        check("unf_flag", 32'(ras_underflow), 32'h1);
        check("unf_pc", 32'(pc), 32'h6);

        // Interrupt entry, no nesting, return re-enables
        reset_dut();
        clear(); int_en_cmd = 1'b1;
        tick();
        jump_to(12'd30);
        check("pc_at_40", 32'(pc), 32'h0040);
        int_req = 1'b1;
        tick();
        check("isr_pc", 32'(pc), 32'h0010);
        check("isr_active", 32'(int_active), 32'h1);
        tick();
        tick();
        check("no_nest", 32'(pc), 32'h0014);
        clear(); ret = 1'b1;
        tick();
        check("isr_ret_pc", 32'(pc), 32'h0042);
        check("isr_ret_active", 32'(int_active), 32'h0);
        clear(); int_req = 1'b1;
        tick();
        check("ie_restored", 32'(pc), 32'h0010);

        // Halt, wake by interrupt, reset mid-ISR
        reset_dut();
        clear(); int_en_cmd = 1'b1;
        tick();
        jump_to(12'd14);
        halt = 1'b1;
        tick();
        tick();
        check("halt_pc", 32'(pc), 32'h0020);
        check("halt_flag", 32'(halted), 32'h1);
        clear(); int_req = 1'b1;
        tick();
        check("wake_pc", 32'(pc), 32'h0010);
        clear(); ret = 1'b1;
        tick();
        check("wake_ret", 32'(pc), 32'h0022);
        tick();
        clear(); int_req = 1'b1;
        tick();
        clear();
        tick();
        reset_dut();
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_unf", 32'(ras_underflow), 32'h0);
        check("rst_active", 32'(int_active), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            clk_en       = ($urandom_range(0, 9) != 0);
            halt         = ($urandom_range(0, 49) == 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            branch_imm   = BR_W'($urandom);
            jump_taken   = ($urandom_range(0, 7) == 0);
            jump_link    = ($urandom_range(0, 1) == 0);
            jump_imm     = J_W'($urandom);
            ret          = ($urandom_range(0, 6) == 0);
            int_en_cmd   = ($urandom_range(0, 11) == 0);
            int_dis_cmd  = ($urandom_range(0, 31) == 0);
            int_req      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 249) == 0) reset_dut();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
